// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width and status flag layout.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 5;

  localparam int unsigned FLAG_C = 3;
  localparam int unsigned FLAG_V = 2;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_Z = 0;

  // Status flags; the field order gives c = bit 3 down to z = bit 0.
  typedef struct packed {
    logic c;
    logic v;
    logic n;
    logic z;
  } alu_flags_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Derives C/V/N/Z from adder operands, result and carry-out.
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [WIDTH-1:0] result,
  input  logic             carry,
  output logic [3:0]       flags
);

  localparam int unsigned MSB = WIDTH - 1;

  alu_flags_t f;

  // Signed overflow: same-sign operands producing a result of the other sign.
  always_comb begin
    f   = '0;
    f.c = carry;
    f.v = (operand_a[MSB] == operand_b[MSB]) && (result[MSB] != operand_a[MSB]);
    f.n = result[MSB];
    f.z = (result == '0);
  end

  assign flags = f;

endmodule

// File: rtl/alu_result_stage.sv
// Adder result stage: flag generation, 2-entry in-order FIFO and carry counter.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_operand_a,
  input  logic [WIDTH-1:0] in_operand_b,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  input  logic             clr_count,
  output logic [CNT_W-1:0] carry_count
);

  localparam int unsigned OCC_W = 2;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [OCC_W-1:0] occ, occ_next;
  logic             rd_ptr, wr_ptr;
  logic [WIDTH-1:0] mem_result [2];
  alu_flags_t       mem_flags  [2];

  logic [3:0]       new_flags_raw;
  alu_flags_t       new_flags;
  logic             accept, pop, carry_accept;
  logic             head_slot;
  logic [WIDTH-1:0] head_result;
  alu_flags_t       head_flags;
  logic [CNT_W-1:0] count_next;

  alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .operand_a (in_operand_a),
    .operand_b (in_operand_b),
    .result    (in_result),
    .carry     (in_carry),
    .flags     (new_flags_raw)
  );

  assign new_flags    = alu_flags_t'(new_flags_raw);
  assign accept       = in_valid && in_ready;
  assign pop          = out_valid && out_ready;
  assign carry_accept = accept && new_flags.c;

  // Next occupancy, next head contents and next carry count.
  always_comb begin
    occ_next    = occ;
    head_slot   = rd_ptr;
    head_result = mem_result[rd_ptr];
    head_flags  = mem_flags[rd_ptr];
    count_next  = carry_count;

    case ({accept, pop})
      2'b10:   occ_next = occ + OCC_W'(1);
      2'b01:   occ_next = occ - OCC_W'(1);
      default: occ_next = occ;
    endcase

    // Head after this edge: next slot on a pop, bypassing a same-edge write.
    head_slot = pop ? ~rd_ptr : rd_ptr;
    if (accept && (wr_ptr == head_slot)) begin
      head_result = in_result;
      head_flags  = new_flags;
    end else begin
      head_result = mem_result[head_slot];
      head_flags  = mem_flags[head_slot];
    end

    if (clr_count) begin
      count_next = carry_accept ? CNT_W'(1) : '0;
    end else if (carry_accept && (carry_count != CNT_MAX)) begin
      count_next = carry_count + CNT_W'(1);
    end
  end

  // FIFO state, registered status/outputs and counter; outputs hold when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ           <= '0;
      rd_ptr        <= 1'b0;
      wr_ptr        <= 1'b0;
      mem_result[0] <= '0;
      mem_result[1] <= '0;
      mem_flags[0]  <= '0;
      mem_flags[1]  <= '0;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_flags     <= '0;
      carry_count   <= '0;
    end else begin
      if (accept) begin
        mem_result[wr_ptr] <= in_result;
        mem_flags[wr_ptr]  <= new_flags;
        wr_ptr             <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      occ       <= occ_next;
      in_ready  <= (occ_next != OCC_W'(2));
      out_valid <= (occ_next != OCC_W'(0));
      if (occ_next != OCC_W'(0)) begin
        out_result <= head_result;
        out_flags  <= head_flags;
      end
      carry_count <= count_next;
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: vector table, directed sequences, random.
module tb_alu_result_stage;

  localparam int unsigned WIDTH = 5;
  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_operand_a;
  logic [WIDTH-1:0] in_operand_b;
  logic [WIDTH-1:0] in_result;
  logic             in_carry;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [3:0]       out_flags;
  logic             clr_count;
  logic [CNT_W-1:0] carry_count;

  alu_result_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_operand_a (in_operand_a),
    .in_operand_b (in_operand_b),
    .in_result    (in_result),
    .in_carry     (in_carry),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_flags    (out_flags),
    .clr_count    (clr_count),
    .carry_count  (carry_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a queue of {result, flags}, the visible head and a counter.
  typedef struct {
    int res;
    int flags;
  } ent_t;

  ent_t q[$];
  int   shown_res   = 0;
  int   shown_flags = 0;
  int   m_cnt       = 0;
  int   n_pops      = 0;

  function automatic int ref_flags(int a, int b, int res, int c);
    int sa, sb, s, v;
    sa = (a >= 16) ? a - 32 : a;
    sb = (b >= 16) ? b - 32 : b;
    s  = sa + sb;
    v  = (s > 15 || s < -16) ? 1 : 0;
    return (c * 8) + (v * 4) + ((res >= 16) ? 2 : 0) + ((res == 0) ? 1 : 0);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("out_valid", int'(out_valid), (q.size() > 0) ? 1 : 0);
    chk("in_ready", int'(in_ready), (q.size() < 2) ? 1 : 0);
    chk("carry_count", int'(carry_count), m_cnt);
    chk("out_result", int'(out_result), shown_res);
    chk("out_flags", int'(out_flags), shown_flags);
  endtask

  task automatic model_reset();
    q.delete();
    shown_res   = 0;
    shown_flags = 0;
    m_cnt       = 0;
  endtask

  // One clock: advance the model from the inputs in force at the edge, then check.
  task automatic step();
    bit   acc, pp;
    ent_t e;
    @(posedge clk);
    acc = in_valid && (q.size() < 2);
    pp  = out_ready && (q.size() > 0);
    if (pp) begin
      void'(q.pop_front());
      n_pops++;
    end
    if (acc) begin
      e.res   = int'(in_result);
      e.flags = ref_flags(int'(in_operand_a), int'(in_operand_b), int'(in_result), int'(in_carry));
      q.push_back(e);
    end
    if (clr_count) m_cnt = (acc && in_carry) ? 1 : 0;
    else if (acc && in_carry && m_cnt < 255) m_cnt++;
    if (q.size() > 0) begin
      shown_res   = q[0].res;
      shown_flags = q[0].flags;
    end
    #1;
    check_model();
  endtask

  // Present a true adder result for a + b.
  task automatic drive(input bit v, input int a, input int b);
    int s;
    s            = a + b;
    in_valid     = v;
    in_operand_a = WIDTH'(a);
    in_operand_b = WIDTH'(b);
    in_result    = WIDTH'(s);
    in_carry     = (s >= 32);
  endtask

  typedef struct {
    int a;
    int b;
    int exp_res;
    int exp_flags;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{a: 5'b01111, b: 5'b00001, exp_res: 5'b10000, exp_flags: 4'b0110};
    tbl[1] = '{a: 5'b10000, b: 5'b10000, exp_res: 5'b00000, exp_flags: 4'b1101};
    tbl[2] = '{a: 5'b00000, b: 5'b00000, exp_res: 5'b00000, exp_flags: 4'b0001};
    tbl[3] = '{a: 5'b11111, b: 5'b00001, exp_res: 5'b00000, exp_flags: 4'b1001};
    tbl[4] = '{a: 5'b00101, b: 5'b00011, exp_res: 5'b01000, exp_flags: 4'b0000};
    tbl[5] = '{a: 5'b11000, b: 5'b11000, exp_res: 5'b10000, exp_flags: 4'b1010};
    tbl[6] = '{a: 5'b10000, b: 5'b11111, exp_res: 5'b01111, exp_flags: 4'b1100};
    tbl[7] = '{a: 5'b01000, b: 5'b01000, exp_res: 5'b10000, exp_flags: 4'b0110};

    rst_n     = 1'b0;
    out_ready = 1'b0;
    clr_count = 1'b0;
    drive(1'b0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_result", int'(out_result), 0);
    chk("rst_out_flags", int'(out_flags), 0);
    chk("rst_carry_count", int'(carry_count), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors: accept into empty FIFO, check head, then pop it.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, tbl[i].a, tbl[i].b);
      out_ready = 1'b0;
      step();
      drive(1'b0, 0, 0);
      chk("tbl_valid", int'(out_valid), 1);
      chk("tbl_result", int'(out_result), tbl[i].exp_res);
      chk("tbl_flags", int'(out_flags), tbl[i].exp_flags);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("tbl_hold_result", int'(out_result), tbl[i].exp_res);
    end
    chk("tbl_carry_count", int'(carry_count), 4);

    // Backpressure: three results offered with out_ready low.
    out_ready = 1'b0;
    drive(1'b1, 1, 0);
    step();
    drive(1'b1, 2, 0);
    step();
    chk("bp_full_ready", int'(in_ready), 0);
    drive(1'b1, 3, 0);
    step();
    chk("bp_hold_head", int'(out_result), 1);
    out_ready = 1'b1;
    step();
    chk("bp_head2", int'(out_result), 2);
    chk("bp_ready_back", int'(in_ready), 1);
    step();
    chk("bp_head3", int'(out_result), 3);
    drive(1'b0, 0, 0);
    step();
    chk("bp_empty", int'(out_valid), 0);
    chk("bp_last_popped", int'(out_result), 3);

    // Streaming: 20 back-to-back results with out_ready high.
    n_pops = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, i + 4, 0);
      step();
      chk("stream_head", int'(out_result), i + 4);
      chk("stream_occ1", int'(in_ready), 1);
    end
    drive(1'b0, 0, 0);
    step();
    chk("stream_pops", n_pops, 20);
    out_ready = 1'b0;

    // Mid-stream reset with two buffered entries.
    drive(1'b1, 31, 31);
    step();
    step();
    drive(1'b0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_ready", int'(in_ready), 1);
    chk("mid_rst_count", int'(carry_count), 0);
    chk("mid_rst_result", int'(out_result), 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 9, 9);
    step();
    chk("post_rst_accept", int'(out_result), 18);
    drive(1'b0, 0, 0);
    out_ready = 1'b1;
    step();

    // Counter saturation and clear interactions.
    clr_count = 1'b1;
    step();
    clr_count = 1'b0;
    for (int i = 0; i < 255; i++) begin
      drive(1'b1, 16 + (i % 16), 16);
      step();
    end
    chk("cnt_255", int'(carry_count), 255);
    drive(1'b1, 31, 1);
    step();
    chk("cnt_sat", int'(carry_count), 255);
    clr_count = 1'b1;
    step();
    chk("cnt_clr_with_carry", int'(carry_count), 1);
    drive(1'b0, 0, 0);
    step();
    chk("cnt_clr_alone", int'(carry_count), 0);
    clr_count = 1'b0;

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
      out_ready = ($urandom_range(0, 3) != 0);
      clr_count = ($urandom_range(0, 31) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
